execute_mdu: RTL

Parametrised RV32IM execute stage between decode/regread and memory/writeback. Resolves branches and jumps, produces data-memory requests, and computes the full RV32I ALU set in one cycle. When enabled, it also runs M-extension multiply/divide on an iterative unit that stalls the upstream handshake. Output is a registered pipeline slot with a valid/ready handshake and a synchronous flush.

---
 rtl/execute_mdu.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_mdu.sv
// RV32IM execute stage: single-cycle ALU/branch/memory-request decode plus an iterative multiply/divide unit.
// Latency: one cycle for ALU ops, 32/ITER_BITS cycles for M ops; upstream is stalled while the output slot is blocked or the M unit is busy.
module execute_mdu #(
    parameter int M_EXT     = 1,
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        valid_ro,
    input  logic        ready_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] r0data_i,
    input  logic [31:0] r1data_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro,
    output logic [31:0] r0data_ro,
    output logic [31:0] r1data_ro,
    output logic [31:0] result_ro,
    output logic        busy_o,
    output logic [31:0] jumpaddr_o,
    output logic        jumptaken_o,
    output logic [31:0] datamemaddr_o,
    output logic [31:0] datamemdata_o,
    output logic        datamemwrite_o,
    output logic [1:0]  datamemwidth_o
);
    localparam int N = 32 / ITER_BITS;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign alt    = (funct7 == 7'b0100000);
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub_sra,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000: r = sub_sra ? a - b : a + b;
            3'b001: r = a << b[4:0];
            3'b010: r = {31'b0, $signed(a) < $signed(b)};
            3'b011: r = {31'b0, a < b};
            3'b100: r = a ^ b;
            3'b101: begin
                if (sub_sra) r = $signed(a) >>> b[4:0];
                else         r = a >> b[4:0];
            end
            3'b110: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Operand signedness of the M ops: MULHSU treats only rs1 as signed, the U forms neither.
    function automatic logic a_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        return f3[2] ? ~f3[0] : ~f3[1];
    endfunction

    logic [31:0] res;
    logic [31:0] target;
    logic        take;
    logic        m_op;
    logic        store_ok;
    logic        accept;

    always_comb begin
        res      = 32'hFFFFFFFF;
        target   = pc_i + imm_b;
        take     = 1'b0;
        m_op     = 1'b0;
        store_ok = 1'b0;
        case (opcode)
            OPC_LUI:   res = imm_u;
            OPC_AUIPC: res = pc_i + imm_u;
            OPC_JAL: begin
                res    = pc_i + 32'd4;
                take   = 1'b1;
                target = pc_i + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    res    = pc_i + 32'd4;
                    take   = 1'b1;
                    target = (r0data_i + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (funct3[2:1] != 2'b01) begin
                    res = 32'd0;
                    case (funct3)
                        3'b000:  take = (r0data_i == r1data_i);
                        3'b001:  take = (r0data_i != r1data_i);
                        3'b100:  take = ($signed(r0data_i) <  $signed(r1data_i));
                        3'b101:  take = ($signed(r0data_i) >= $signed(r1data_i));
                        3'b110:  take = (r0data_i <  r1data_i);
                        default: take = (r0data_i >= r1data_i);
                    endcase
                end
            end
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    res = r0data_i + imm_i;
            end
            OPC_STORE: begin
                if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
                    res      = r0data_i + imm_s;
                    store_ok = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0) res = alu(funct3, 1'b0, r0data_i, imm_i);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0 || alt) res = alu(funct3, alt, r0data_i, imm_i);
                end else begin
                    res = alu(funct3, 1'b0, r0data_i, imm_i);
                end
            end
            OPC_OP: begin
                if (funct7 == 7'b0000001) begin
                    m_op = (M_EXT != 0);
                end else if (funct7 == 7'b0 || (alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    res = alu(funct3, alt, r0data_i, r1data_i);
                end
            end
            default: res = 32'hFFFFFFFF;
        endcase
    end

    assign ready_o        = (state == IDLE) & (~valid_ro | ready_i) & ~flush_i;
    assign accept         = valid_i & ready_o;
    assign busy_o         = (state == CALC);
    assign jumpaddr_o     = target;
    assign jumptaken_o    = accept & take;
    assign datamemaddr_o  = r0data_i + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign datamemdata_o  = r1data_i;
    assign datamemwrite_o = accept & store_ok;
    assign datamemwidth_o = funct3[1:0];

    // Iterative unit works on magnitudes; operands come from the latched slot registers.
    logic [2:0]  m_f3;
    logic        a_neg, b_neg;
    logic [31:0] a_mag_in, b_mag;
    logic [63:0] acc_nx, prod;
    logic [32:0] t, s;
    logic        qb;
    logic [31:0] quo, rem, m_res;

    assign m_f3     = inst_ro[14:12];
    assign a_neg    = a_signed(m_f3) & r0data_ro[31];
    assign b_neg    = b_signed(m_f3) & r1data_ro[31];
    assign b_mag    = b_neg ? -r1data_ro : r1data_ro;
    assign a_mag_in = (a_signed(funct3) & r0data_i[31]) ? -r0data_i : r0data_i;

    always_comb begin
        acc_nx = acc;
        t      = 33'd0;
        s      = 33'd0;
        qb     = 1'b0;
        for (int k = 0; k < ITER_BITS; k++) begin
            if (m_f3[2]) begin
                // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
                t  = {acc_nx[63:32], acc_nx[31]};
                qb = (t >= {1'b0, b_mag});
                if (qb) t = t - {1'b0, b_mag};
                acc_nx = {t[31:0], acc_nx[30:0], qb};
            end else begin
                s      = {1'b0, acc_nx[63:32]} + (acc_nx[0] ? {1'b0, b_mag} : 33'd0);
                acc_nx = {s, acc_nx[31:1]};
            end
        end
    end

    assign prod = (a_neg ^ b_neg) ? -acc_nx : acc_nx;
    assign quo  = (a_neg ^ b_neg) ? -acc_nx[31:0] : acc_nx[31:0];
    assign rem  = a_neg ? -acc_nx[63:32] : acc_nx[63:32];

    always_comb begin
        case (m_f3)
            3'b000:         m_res = prod[31:0];
            3'b100, 3'b101: m_res = (r1data_ro == 32'd0) ? 32'hFFFFFFFF : quo;
            3'b110, 3'b111: m_res = (r1data_ro == 32'd0) ? r0data_ro : rem;
            default:        m_res = prod[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            acc       <= 64'd0;
            valid_ro  <= 1'b0;
            pc_ro     <= 32'd0;
            inst_ro   <= 32'd0;
            r0data_ro <= 32'd0;
            r1data_ro <= 32'd0;
            result_ro <= 32'd0;
        end else if (flush_i) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            valid_ro <= 1'b0;
        end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + 5'd1;
            if (cnt == CNT_LAST) begin
                result_ro <= m_res;
                valid_ro  <= 1'b1;
                state     <= IDLE;
                cnt       <= 5'd0;
            end
        end else if (accept) begin
            pc_ro     <= pc_i;
            inst_ro   <= inst_i;
            r0data_ro <= r0data_i;
            r1data_ro <= r1data_i;
            if (m_op) begin
                valid_ro <= 1'b0;
                state    <= CALC;
                cnt      <= 5'd0;
                acc      <= {32'd0, a_mag_in};
            end else begin
                valid_ro  <= 1'b1;
                result_ro <= res;
            end
        end else if (ready_i) begin
            valid_ro <= 1'b0;
        end
    end
endmodule
